// File: rtl/add_pipe_pkg.sv
// add_pipe_pkg: shared op encoding and default result beat layout for add_pipe
package add_pipe_pkg;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_ACC, OP_CLR} op_e;
  localparam int DATA_WIDTH_DEF = 4;
  localparam int ACC_WIDTH_DEF = 8;
  typedef struct packed {
    logic [DATA_WIDTH_DEF:0] x;
    logic [ACC_WIDTH_DEF-1:0] acc;
    logic ovf;
  } result_t;
endpackage

// File: rtl/add_pipe_stage.sv
// add_pipe_stage: one valid/ready register slice carrying a result beat (clk, rst_n, in_valid/in_ready/in_data, out_valid/out_ready/out_data)
module add_pipe_stage
  import add_pipe_pkg::*;
#(
  parameter type T = result_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);
  assign in_ready = !out_valid || out_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
endmodule

// File: rtl/add_pipe.sv
// add_pipe: streaming ADD/SUB/ACC/CLR unit with STAGES-deep valid/ready pipeline; ports clk, rst_n, in_valid/in_ready/in_op/in_a/in_b, out_valid/out_ready/out_x/out_acc/out_ovf; ADD_PIPE_SAT_EN selects saturating accumulator
module add_pipe
  import add_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ACC_WIDTH = ACC_WIDTH_DEF,
  parameter int STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_op,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH:0]   out_x,
  output logic [ACC_WIDTH-1:0]  out_acc,
  output logic                  out_ovf
);
  typedef struct packed {
    logic [DATA_WIDTH:0] x;
    logic [ACC_WIDTH-1:0] acc;
    logic ovf;
  } beat_t;
  op_e op;
  logic [ACC_WIDTH-1:0] acc, acc_add, acc_nxt;
  logic [DATA_WIDTH:0] sum, dif;
  logic [ACC_WIDTH:0] ext;
  logic [STAGES:0] v, r;
  beat_t d [0:STAGES];
  assign op = op_e'(in_op);
  always_comb begin
    sum = {1'b0, in_a} + {1'b0, in_b};
    dif = {1'b0, in_a} - {1'b0, in_b};
    ext = {1'b0, acc} + (ACC_WIDTH+1)'(sum);
`ifdef ADD_PIPE_SAT_EN
    acc_add = ext[ACC_WIDTH] ? '1 : ext[ACC_WIDTH-1:0];
`else
    acc_add = ext[ACC_WIDTH-1:0];
`endif
    acc_nxt = op == OP_ACC ? acc_add : op == OP_CLR ? '0 : acc;
    d[0].x = op == OP_SUB ? dif : op == OP_CLR ? '0 : sum;
    d[0].acc = acc_nxt;
    d[0].ovf = op == OP_ACC && ext[ACC_WIDTH];
  end
  // accumulator moves at accept time so back-to-back ACC beats chain without waiting for the pipe
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) acc <= '0;
    else if (in_valid && in_ready) acc <= acc_nxt;
  assign v[0] = in_valid;
  assign in_ready = r[0];
  assign r[STAGES] = out_ready;
  assign out_valid = v[STAGES];
  assign out_x = d[STAGES].x;
  assign out_acc = d[STAGES].acc;
  assign out_ovf = d[STAGES].ovf;
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    add_pipe_stage #(.T(beat_t)) u_stage (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(v[k]),
      .in_ready(r[k]),
      .in_data(d[k]),
      .out_valid(v[k+1]),
      .out_ready(r[k+1]),
      .out_data(d[k+1])
    );
  end
endmodule
